// File: rtl/vga_pkg.sv
// Shared constants for the VGA frame-capture block: image size defaults,
// standard 640x480 timing (800x525 totals) and capture FSM state encodings.
package vga_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_VSYNC   = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/vga_frame_capture_if.sv
// Frame-buffer write port driven by the capture block.
interface vga_frame_capture_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic [9:0]        cur_x;
  logic [8:0]        cur_y;

  modport master (output wr_en, wr_addr, wr_data, cur_x, cur_y);
  modport slave  (input  wr_en, wr_addr, wr_data, cur_x, cur_y);
endinterface

// File: rtl/vga_sync_edge.sv
// Registers the VGA-side inputs once (s1), keeps the previous sample (s2)
// and produces single-cycle rise/fall pulses for hs, vs and blank_n.
module vga_sync_edge #(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             blank_n_in,
  input  logic [PIX_W-1:0] pix_in,
  output logic             blank_n,
  output logic [PIX_W-1:0] pix,
  output logic             hs_rise,
  output logic             hs_fall,
  output logic             vs_rise,
  output logic             vs_fall,
  output logic             blank_rise,
  output logic             blank_fall
);

  // bit 2 = hs, bit 1 = vs, bit 0 = blank_n
  logic [2:0]       sync_s1_q, sync_s1_d;
  logic [2:0]       sync_s2_q, sync_s2_d;
  logic [PIX_W-1:0] pix_s1_q, pix_s1_d;

  // Next-state of the two-deep sync history and the one-deep pixel stage
  always_comb begin
    sync_s1_d = {hs_in, vs_in, blank_n_in};
    sync_s2_d = sync_s1_q;
    pix_s1_d  = pix_in;
  end

  // Input sample registers, cleared on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_s1_q <= '0;
      sync_s2_q <= '0;
      pix_s1_q  <= '0;
    end else begin
      sync_s1_q <= sync_s1_d;
      sync_s2_q <= sync_s2_d;
      pix_s1_q  <= pix_s1_d;
    end
  end

  // Edge pulses compare the previous sample against the current one
  always_comb begin
    blank_n    = sync_s1_q[0];
    pix        = pix_s1_q;
    hs_rise    = ~sync_s2_q[2] &  sync_s1_q[2];
    hs_fall    =  sync_s2_q[2] & ~sync_s1_q[2];
    vs_rise    = ~sync_s2_q[1] &  sync_s1_q[1];
    vs_fall    =  sync_s2_q[1] & ~sync_s1_q[1];
    blank_rise = ~sync_s2_q[0] &  sync_s1_q[0];
    blank_fall =  sync_s2_q[0] & ~sync_s1_q[0];
  end

endmodule

// File: rtl/vga_frame_capture.sv
// Grabs one full frame from the VGA output signals on request, rebuilding
// pixel coordinates from vsync and blanking, and writes it to a frame buffer.
module vga_frame_capture
  import vga_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vga_hs,
  input  logic             vga_vs,
  input  logic             vga_blank_n,
  input  logic [PIX_W-1:0] vga_pix,
  input  logic             capture_req,
  output logic             busy,
  output logic             done,
  output logic             frame_err,
  vga_frame_capture_if.master fb
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [9:0]        X_END     = 10'(IMG_W);

  logic             blank_n_s1, vs_rise, vs_fall, blank_fall;
  logic [PIX_W-1:0] pix_s1;

  vga_sync_edge #(.PIX_W(PIX_W)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .hs_in      (vga_hs),
    .vs_in      (vga_vs),
    .blank_n_in (vga_blank_n),
    .pix_in     (vga_pix),
    .blank_n    (blank_n_s1),
    .pix        (pix_s1),
    .hs_rise    (),
    .hs_fall    (),
    .vs_rise    (vs_rise),
    .vs_fall    (vs_fall),
    .blank_rise (),
    .blank_fall (blank_fall)
  );

  logic [2:0]        state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [9:0]        x_q, x_d;
  logic [8:0]        y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]  wr_data_q, wr_data_d;
  logic [9:0]        cur_x_q, cur_x_d;
  logic [8:0]        cur_y_q, cur_y_d;
  logic              writing;

  // Capture FSM plus coordinate/address counters; the last write wins over
  // a coincident vsync so a complete frame never reports an error
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    writing   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture_req) begin
          state_d = ST_ARM;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end
      end
      ST_ARM: begin
        if (vs_fall) state_d = ST_VSYNC;
      end
      ST_VSYNC: begin
        if (vs_rise) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (blank_n_s1 && (x_q < X_END)) begin
          writing   = 1'b1;
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = pix_s1;
          cur_x_d   = x_q;
          cur_y_d   = y_q;
          x_d       = x_q + 10'd1;
          addr_d    = addr_q + ADDR_W'(1);
        end else if (blank_n_s1) begin
          err_d = 1'b1;
        end
        if (blank_fall && (x_q != 10'd0)) begin
          y_d = y_q + 9'd1;
          x_d = '0;
          if (x_q != X_END) err_d = 1'b1;
        end
        if (writing && (addr_q == LAST_ADDR)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (vs_fall) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any capture silently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign frame_err  = err_q;
  assign fb.wr_en   = wr_en_q;
  assign fb.wr_addr = wr_addr_q;
  assign fb.wr_data = wr_data_q;
  assign fb.cur_x   = cur_x_q;
  assign fb.cur_y   = cur_y_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture using a reduced 16x8 image with a
// 24x12 total raster so several complete frames fit in a short run.
module tb_vga_frame_capture;

  localparam int IMG_W    = 16;
  localparam int IMG_H    = 8;
  localparam int PIX_W    = 8;
  localparam int ADDR_W   = 8;
  localparam int H_TOT    = 24;
  localparam int HS_START = 18;
  localparam int HS_END   = 21;
  localparam int V_TOT    = 12;
  localparam int VS_START = 9;
  localparam int VS_END   = 11;

  logic             clk = 1'b0;
  logic             reset;
  logic             vga_hs, vga_vs, vga_blank_n, capture_req;
  logic [PIX_W-1:0] vga_pix;
  logic             busy, done, frame_err;

  int n_cmp = 0;
  int n_bad = 0;

  vga_frame_capture_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) fb ();

  vga_frame_capture #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PIX_W (PIX_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_blank_n(vga_blank_n),
    .vga_pix    (vga_pix),
    .capture_req(capture_req),
    .busy       (busy),
    .done       (done),
    .frame_err  (frame_err),
    .fb         (fb.master)
  );

  always #5 clk = ~clk;

  // Write-port monitor: counts writes and done pulses, stores written pixels
  // and flags any write whose address breaks the 0,1,2,... sequence
  int         wr_total   = 0;
  int         done_total = 0;
  int         seq_bad    = 0;
  int         last_addr  = 0;
  bit         in_cap     = 1'b0;
  logic [7:0] mem [0:127];

  always @(negedge clk) begin
    if (fb.wr_en) begin
      wr_total++;
      if (int'(fb.wr_addr) != (in_cap ? last_addr + 1 : 0)) seq_bad++;
      last_addr = int'(fb.wr_addr);
      mem[fb.wr_addr[6:0]] = fb.wr_data;
      in_cap = 1'b1;
    end else if (!busy) begin
      in_cap = 1'b0;
    end
    if (done) done_total++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0d (0x%0h), required %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Drives one raster frame cycle by cycle; pixel = (h+v) mod 256 unless
  // the bright flag puts 0xFF at (0,0). Negative line numbers disable events.
  task automatic drive_frame(input int req_line, input int req2_line, input int short_line,
                             input int early_vs, input int reset_line, input bit bright);
    int lat_cd;
    int line_len;
    lat_cd = -1;
    for (int v = 0; v < V_TOT; v++) begin
      for (int h = 0; h < H_TOT; h++) begin
        @(negedge clk);
        reset       = 1'b0;
        line_len    = (v == short_line) ? IMG_W - 1 : IMG_W;
        vga_blank_n = (v < IMG_H) && (h < line_len);
        vga_hs      = !(h >= HS_START && h < HS_END);
        vga_vs      = !((v >= VS_START && v < VS_END) ||
                        (v == early_vs && h >= HS_START && h < HS_END));
        vga_pix     = (bright && v == 0 && h == 0) ? 8'hFF : 8'((h + v) % 256);
        capture_req = (h == 5) && (v == req_line || v == req2_line);
        if (lat_cd > 0) begin
          lat_cd--;
          if (lat_cd == 1) check_output("lat_not_early", 32'(fb.wr_en), 32'd0);
          if (lat_cd == 0) begin
            check_output("lat_wr_en", 32'(fb.wr_en), 32'd1);
            check_output("lat_wr_addr", 32'(fb.wr_addr), 32'd0);
            check_output("lat_wr_data", 32'(fb.wr_data), 32'hFF);
          end
        end
        if (bright && v == 0 && h == 0) lat_cd = 2;
        if (v == req_line && h == 6) begin
          check_output("req_busy", 32'(busy), 32'd1);
          check_output("req_err_clear", 32'(frame_err), 32'd0);
        end
        if (v == short_line && h == 0) check_output("short_err_before", 32'(frame_err), 32'd0);
        if (v == short_line && h == IMG_W + 1) check_output("short_err_at_fall", 32'(frame_err), 32'd1);
        if (v == reset_line && h == 0) begin
          #2 reset = 1'b1;
          #1;
          check_output("rst_busy", 32'(busy), 32'd0);
          check_output("rst_wr_en", 32'(fb.wr_en), 32'd0);
          check_output("rst_done", 32'(done), 32'd0);
        end
      end
    end
  endtask

  int base_wr;
  int base_done;

  initial begin
    reset       = 1'b1;
    vga_hs      = 1'b1;
    vga_vs      = 1'b1;
    vga_blank_n = 1'b0;
    vga_pix     = '0;
    capture_req = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_err", 32'(frame_err), 32'd0);
    check_output("reset_wr_en", 32'(fb.wr_en), 32'd0);
    check_output("reset_wr_addr", 32'(fb.wr_addr), 32'd0);
    check_output("reset_wr_data", 32'(fb.wr_data), 32'd0);
    check_output("reset_cur_x", 32'(fb.cur_x), 32'd0);
    check_output("reset_cur_y", 32'(fb.cur_y), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] full frame with latency probe and ignored second request");
    drive_frame(2, -1, -1, -1, -1, 1'b0);
    base_wr   = wr_total;
    base_done = done_total;
    drive_frame(-1, 3, -1, -1, -1, 1'b1);
    check_output("full_writes", 32'(wr_total - base_wr), 32'd128);
    check_output("full_seq", 32'(seq_bad), 32'd0);
    check_output("full_last_addr", 32'(last_addr), 32'd127);
    check_output("full_pix_0_0", 32'(mem[0]), 32'hFF);
    check_output("full_pix_5_3", 32'(mem[3*16+5]), 32'd8);
    check_output("full_pix_15_7", 32'(mem[127]), 32'd22);
    check_output("full_done", 32'(done_total - base_done), 32'd1);
    check_output("full_err", 32'(frame_err), 32'd0);
    check_output("full_busy_after", 32'(busy), 32'd0);
    drive_frame(-1, -1, -1, -1, -1, 1'b0);
    check_output("busy_req_one_done", 32'(done_total - base_done), 32'd1);

    $display("[TB] short line 5");
    drive_frame(2, -1, -1, -1, -1, 1'b0);
    base_wr   = wr_total;
    base_done = done_total;
    drive_frame(-1, -1, 5, -1, -1, 1'b0);
    check_output("short_writes", 32'(wr_total - base_wr), 32'd127);
    check_output("short_done", 32'(done_total - base_done), 32'd1);
    check_output("short_err_sticky", 32'(frame_err), 32'd1);

    $display("[TB] early vsync after line 3");
    drive_frame(2, -1, -1, -1, -1, 1'b0);
    base_wr   = wr_total;
    base_done = done_total;
    drive_frame(-1, -1, -1, 3, -1, 1'b0);
    check_output("early_writes", 32'(wr_total - base_wr), 32'd64);
    check_output("early_last_addr", 32'(last_addr), 32'd63);
    check_output("early_done", 32'(done_total - base_done), 32'd1);
    check_output("early_err", 32'(frame_err), 32'd1);

    $display("[TB] reset at line 4 of capture");
    drive_frame(2, -1, -1, -1, -1, 1'b0);
    base_done = done_total;
    drive_frame(-1, -1, -1, -1, 4, 1'b0);
    check_output("rst_no_done", 32'(done_total - base_done), 32'd0);
    check_output("rst_idle_busy", 32'(busy), 32'd0);

    $display("[TB] fresh capture after reset");
    drive_frame(2, -1, -1, -1, -1, 1'b0);
    base_wr   = wr_total;
    base_done = done_total;
    drive_frame(-1, -1, -1, -1, -1, 1'b0);
    check_output("fresh_writes", 32'(wr_total - base_wr), 32'd128);
    check_output("fresh_seq", 32'(seq_bad), 32'd0);
    check_output("fresh_pix_0_0", 32'(mem[0]), 32'd0);
    check_output("fresh_pix_9_2", 32'(mem[2*16+9]), 32'd11);
    check_output("fresh_done", 32'(done_total - base_done), 32'd1);
    check_output("fresh_err", 32'(frame_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_frame_capture.md
Name: vga_frame_capture

Overview:
- Receive end of the VGA output interface: samples the pipeline's VGA-side signals (active-low HS/VS, BLANK_N, 8-bit red/grey pixel) and rebuilds pixel coordinates from sync and blanking alone.
- Captures exactly one 640x480 frame per request and writes it into a frame-buffer write port.
- Serves as the in-fabric counterpart to the output stage, for on-chip frame grab, loopback checks and readback of filtered images.

Parameters:
- IMG_W, 640, active pixels per line
- IMG_H, 480, active lines per frame
- PIX_W, 8, pixel data width
- ADDR_W, 19, frame-buffer address width (must satisfy 2**ADDR_W >= IMG_W*IMG_H)

Ports:
- clk  in  1  pixel clock (VGA_CLK domain)
- reset  in  1  asynchronous, active-high reset
- vga_hs  in  1  horizontal sync, active low
- vga_vs  in  1  vertical sync, active low
- vga_blank_n  in  1  high during visible pixels
- vga_pix  in  PIX_W  pixel value (VGA_R)
- capture_req  in  1  single-cycle request to grab the next full frame
- busy  out  1  high from accepted request until done
- done  out  1  single-cycle pulse when capture ends (good or errored)
- frame_err  out  1  sticky error flag; cleared on next accepted capture_req
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  ADDR_W  write address = y*IMG_W + x
- wr_data  out  PIX_W  pixel to write
- cur_x  out  10  x of the current write
- cur_y  out  9  y of the current write

Behaviour:
- Reset: all outputs 0; FSM = IDLE; input registers and counters cleared. Reset mid-capture aborts with no done pulse.
- Input stage: vga_hs, vga_vs, vga_blank_n and vga_pix are registered once (s1). Previous values (s2) are kept for edge detection.
- Latency: a pixel presented at cycle N appears on wr_en/wr_addr/wr_data at cycle N+2, registered.
- FSM states:
  - IDLE: capture_req=1 -> ARM. Set busy=1, clear frame_err, zero x, y and address. capture_req is ignored while busy.
  - ARM: wait for VS falling edge (s2=1, s1=0) -> VSYNC.
  - VSYNC: wait for VS rising edge -> CAPTURE. This guarantees the capture starts at line 0.
  - CAPTURE:
    - Each cycle with s1 blank_n=1 and x<IMG_W: wr_en=1, wr_data=pixel, then x++ and address++.
    - blank_n falling edge: if x>0, y++ and x=0. If that line's x != IMG_W, set frame_err.
    - Pixels with x>=IMG_W in a line: not written; set frame_err.
    - Address reaches IMG_W*IMG_H (after the last write) -> DONE.
    - VS falling edge before that -> set frame_err, go to DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Simultaneous events: if the last pixel write and a VS falling edge coincide, the write completes, no error is raised, and the FSM goes to DONE.
- Arithmetic: wr_addr is a running counter, not a multiply. The address never exceeds IMG_W*IMG_H-1. cur_x and cur_y are zero-extended.
- A capture_req during a reset cycle is dropped.

Decomposition:
- Shared package vga_pkg: IMG_W/IMG_H defaults, H/V timing constants (800x525 totals), and the capture state enum (IDLE, ARM, VSYNC, CAPTURE, DONE).
- One natural sub-module: vga_sync_edge. It registers the inputs and produces hs/vs/blank rise and fall pulses.
- FSM and counters stay in the top of the block.

Test Plan:
- Full frame: drive standard 800x525 timing with pixel = (x+y) mod 256, then pulse capture_req mid-frame. Required: capture starts at the next frame, exactly 307200 wr_en pulses occur, wr_addr runs 0..307199, the word at addr 100*640+100 = 200, done pulses once, frame_err=0.
- Latency: single bright pixel 0xFF at (0,0) of the captured frame. Required: wr_en=1, wr_addr=0, wr_data=0xFF exactly 2 cycles after it was presented.
- Short line: line 10 has only 639 active pixels. Required: frame_err=1 at that line's blank fall, capture continues, frame_err stays 1 after done.
- Early vsync: VS asserted after line 200. Required: DONE entered, done pulse, frame_err=1, last wr_addr < 201*640.
- Request while busy: second capture_req during CAPTURE. Required: ignored, one done only. A later request after done clears frame_err and captures a fresh frame.
- Reset mid-capture: reset asserted at line 50. Required: busy, wr_en and done go to 0 immediately (asynchronous), no done pulse, FSM back in IDLE.
